// File: rtl/cnn_pkg.sv
// Shared CNN constants and types: feature word format and the last pooling stage geometry.
package cnn_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned FRAC_BITS     = 8;
    localparam int unsigned POOL_CHANNELS = 8;
    localparam int unsigned POOL_H        = 14;
    localparam int unsigned POOL_W        = 14;
    localparam int unsigned IN_DIM        = POOL_CHANNELS * POOL_H * POOL_W;

    typedef logic signed [DATA_WIDTH-1:0] feat_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fc_buf_ram.sv
// Two-bank simple dual-port feature RAM; bank bit is the address MSB.
// Read port has a LAT-deep output pipeline and returns zero for addresses past DEPTH.
module fc_buf_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 12,
    parameter int unsigned AW         = 4,
    parameter int unsigned LAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  wr_bank,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic                  rd_bank,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned SLOTS = 2 ** (AW + 1);

    logic [DATA_WIDTH-1:0] mem [SLOTS];
    logic [DATA_WIDTH-1:0] pipe_q [LAT];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  in_range;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign in_range = {1'b0, rd_addr} < (AW + 1)'(DEPTH);
    assign rd_word  = in_range ? mem[{rd_bank, rd_addr}] : '0;

    if (LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_q[0] <= '0;
            end else if (re) begin
                pipe_q[0] <= rd_word;
            end
        end
    end else begin : g_latn
        // vld_q[i] marks that stage i loads from stage i-1 at the next edge
        logic [LAT-1:1] vld_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
                for (int unsigned i = 0; i < LAT; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                if (re) begin
                    pipe_q[0] <= rd_word;
                end
                vld_q[1] <= re;
                for (int unsigned i = 2; i < LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
                for (int unsigned i = 1; i < LAT; i++) begin
                    if (vld_q[i]) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
        end
    end

    assign rd_data = pipe_q[LAT-1];

endmodule

// File: rtl/fc_in_buffer.sv
// Ping-pong flatten buffer: pixel-interleaved pooled stream in, channel-major
// dense-layer read port out; a bank is handed to dense once it holds a full frame.
module fc_in_buffer #(
    parameter  int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter  int unsigned CHANNELS   = cnn_pkg::POOL_CHANNELS,
    parameter  int unsigned H          = cnn_pkg::POOL_H,
    parameter  int unsigned W          = cnn_pkg::POOL_W,
    parameter  int unsigned LAT        = 1,
    localparam int unsigned IN_DIM     = CHANNELS * H * W,
    localparam int unsigned AW         = $clog2(IN_DIM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_last,
    output logic                         dense_start,
    input  logic                         dense_done,
    input  logic [AW-1:0]                in_addr,
    input  logic                         in_en,
    output logic signed [DATA_WIDTH-1:0] in_q,
    output logic                         frame_err,
    output logic [1:0]                   bank_full
);

    import cnn_pkg::*;

    localparam int unsigned HW = H * W;
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned YW = (H > 1) ? $clog2(H) : 1;

    logic [CW-1:0] ch_q, ch_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [AW-1:0] pix_base_q, pix_base_d;
    logic [AW-1:0] ch_off_q, ch_off_d;
    logic          wr_sel_q, wr_sel_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          frame_err_q, frame_err_d;

    rd_state_t     rd_state_q;
    logic          rd_sel_q;
    logic          dense_start_q;

    logic          accept;
    logic          ch_last, col_last, row_last, final_beat;
    logic          release_bank;
    logic [AW-1:0] wr_addr;

    assign s_ready      = ~bank_full_q[wr_sel_q];
    assign accept       = s_valid & s_ready;
    assign ch_last      = (ch_q  == CW'(CHANNELS - 1));
    assign col_last     = (col_q == XW'(W - 1));
    assign row_last     = (row_q == YW'(H - 1));
    assign final_beat   = ch_last & col_last & row_last;
    assign wr_addr      = ch_off_q + pix_base_q;
    assign release_bank = (rd_state_q == R_BUSY) & dense_done;

    // Address walks as ch*H*W + (row*W + col); pix_base advances by one per pixel
    // regardless of row wrap, so no multiply is needed.
    always_comb begin
        ch_d        = ch_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_base_d  = pix_base_q;
        ch_off_d    = ch_off_q;
        wr_sel_d    = wr_sel_q;
        bank_full_d = bank_full_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            frame_err_d = frame_err_q | (s_last ^ final_beat);
            if (final_beat) begin
                ch_d       = '0;
                col_d      = '0;
                row_d      = '0;
                pix_base_d = '0;
                ch_off_d   = '0;
                wr_sel_d   = ~wr_sel_q;
            end else if (ch_last) begin
                ch_d       = '0;
                ch_off_d   = '0;
                pix_base_d = pix_base_q + AW'(1);
                if (col_last) begin
                    col_d = '0;
                    row_d = row_q + YW'(1);
                end else begin
                    col_d = col_q + XW'(1);
                end
            end else begin
                ch_d     = ch_q + CW'(1);
                ch_off_d = ch_off_q + AW'(HW);
            end
        end
        if (release_bank) begin
            bank_full_d[rd_sel_q] = 1'b0;
        end
        if (accept && final_beat) begin
            bank_full_d[wr_sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_base_q  <= '0;
            ch_off_q    <= '0;
            wr_sel_q    <= 1'b0;
            bank_full_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_base_q  <= pix_base_d;
            ch_off_q    <= ch_off_d;
            wr_sel_q    <= wr_sel_d;
            bank_full_q <= bank_full_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q    <= R_IDLE;
            rd_sel_q      <= 1'b0;
            dense_start_q <= 1'b0;
        end else begin
            dense_start_q <= 1'b0;
            case (rd_state_q)
                R_IDLE: begin
                    if (bank_full_q[rd_sel_q]) begin
                        dense_start_q <= 1'b1;
                        rd_state_q    <= R_BUSY;
                    end
                end
                R_BUSY: begin
                    if (dense_done) begin
                        rd_sel_q   <= ~rd_sel_q;
                        rd_state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign dense_start = dense_start_q;
    assign frame_err   = frame_err_q;
    assign bank_full   = bank_full_q;

    fc_buf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IN_DIM),
        .AW         (AW),
        .LAT        (LAT)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (accept),
        .wr_bank (wr_sel_q),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .re      (in_en),
        .rd_bank (rd_sel_q),
        .rd_addr (in_addr),
        .rd_data (in_q)
    );

endmodule

// File: tb/tb_fc_in_buffer.sv
// Directed bench for fc_in_buffer at CHANNELS=2, H=2, W=3 (IN_DIM=12); a LAT=3
// copy shares every input so read-latency timing can be checked alongside.
module tb_fc_in_buffer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 s_valid, s_last, dense_done, in_en;
    logic signed [DW-1:0] s_data;
    logic [AW-1:0]        in_addr;
    logic                 s_ready, s_ready3;
    logic                 dense_start, dense_start3;
    logic signed [DW-1:0] in_q, in_q3;
    logic                 frame_err, frame_err3;
    logic [1:0]           bank_full, bank_full3;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned starts   = 0;
    int unsigned starts3  = 0;
    int unsigned wide     = 0;
    logic        start_prev = 1'b0;
    int unsigned s0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [7];

    always #5 clk = ~clk;

    fc_in_buffer #(.DATA_WIDTH(DW), .CHANNELS(2), .H(2), .W(3), .LAT(1)) u_dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .dense_start(dense_start),
        .dense_done(dense_done), .in_addr(in_addr), .in_en(in_en), .in_q(in_q),
        .frame_err(frame_err), .bank_full(bank_full)
    );

    fc_in_buffer #(.DATA_WIDTH(DW), .CHANNELS(2), .H(2), .W(3), .LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready3),
        .s_data(s_data), .s_last(s_last), .dense_start(dense_start3),
        .dense_done(dense_done), .in_addr(in_addr), .in_en(in_en), .in_q(in_q3),
        .frame_err(frame_err3), .bank_full(bank_full3)
    );

    always @(negedge clk) begin
        if (dense_start) starts++;
        if (dense_start3) starts3++;
        if (dense_start && start_prev) wide++;
        start_prev = dense_start;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; dense_done = 1'b0; in_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input int val, input logic last);
        int unsigned w = 0;
        s_valid = 1'b1;
        s_data  = DW'(val);
        s_last  = last;
        while (!s_ready && w < 40) begin
            tick();
            w++;
        end
        if (!s_ready) chk("send_timeout", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic stream(input int base, input int n, input int last_idx);
        for (int i = 0; i < n; i++) send(base + i, i == last_idx);
    endtask

    task automatic read1(input string name, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        in_addr = addr;
        in_en   = 1'b1;
        tick();
        in_en = 1'b0;
        @(negedge clk);
        chk(name, 32'(in_q), 32'(exp));
    endtask

    task automatic pulse_done();
        dense_done = 1'b1;
        tick();
        dense_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{addr: 4'd6,  exp: 16'd1};
        vecs[1] = '{addr: 4'd7,  exp: 16'd3};
        vecs[2] = '{addr: 4'd5,  exp: 16'd10};
        vecs[3] = '{addr: 4'd11, exp: 16'd11};
        vecs[4] = '{addr: 4'd0,  exp: 16'd0};
        vecs[5] = '{addr: 4'd3,  exp: 16'd6};
        vecs[6] = '{addr: 4'd12, exp: 16'd0};

        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        dense_done = 1'b0; in_en = 1'b0; in_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_bank_full", 32'(bank_full), 0);
        chk("rst_dense_start", 32'(dense_start), 0);
        chk("rst_in_q", 32'(in_q), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        tick();

        // Single frame, then table-driven reads of bank 0.
        s0 = starts;
        stream(0, 12, 11);
        @(negedge clk);
        chk("f1_bank_full", 32'(bank_full), 1);
        chk("f1_start_not_yet", 32'(dense_start), 0);
        @(negedge clk);
        chk("f1_start_pulse", 32'(dense_start), 1);
        @(negedge clk);
        chk("f1_start_one_cycle", 32'(dense_start), 0);
        chk("f1_frame_err", 32'(frame_err), 0);
        chk("f1_s_ready", 32'(s_ready), 1);
        for (int i = 0; i < 7; i++) read1($sformatf("f1_rd_addr%0d", vecs[i].addr), vecs[i].addr, vecs[i].exp);
        pulse_done();
        @(negedge clk);
        chk("f1_released", 32'(bank_full), 0);
        chk("f1_starts", starts - s0, 1);

        // Both banks fill, writer stalls, release lets beats 24..35 into bank 0.
        do_reset();
        s0 = starts;
        stream(0, 12, 11);
        stream(12, 12, 11);
        @(negedge clk);
        chk("stall_s_ready", 32'(s_ready), 0);
        chk("stall_bank_full", 32'(bank_full), 3);
        s_valid = 1'b1; s_data = 16'd24; s_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_held", 32'(s_ready), 0);
        dense_done = 1'b1;
        tick();
        dense_done = 1'b0;
        @(negedge clk);
        chk("stall_ready_rise", 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        stream(25, 11, 10);
        repeat (3) tick();
        chk("stall_refull", 32'(bank_full), 3);
        chk("stall_starts2", starts - s0, 2);
        read1("stall_b1_addr6", 4'd6, 16'd13);
        pulse_done();
        repeat (3) tick();
        chk("stall_starts3", starts - s0, 3);
        read1("stall_b0_addr6", 4'd6, 16'd25);
        read1("stall_b0_addr11", 4'd11, 16'd35);
        read1("stall_b0_addr0", 4'd0, 16'd24);

        // Two frames: second start follows the first release; reads from bank 1.
        do_reset();
        s0 = starts;
        stream(0, 12, 11);
        stream(100, 12, 11);
        repeat (3) tick();
        chk("pp_bank_full", 32'(bank_full), 3);
        chk("pp_starts1", starts - s0, 1);
        pulse_done();
        repeat (3) tick();
        chk("pp_starts2", starts - s0, 2);
        chk("pp_bank_full2", 32'(bank_full), 2);
        read1("pp_b1_addr0", 4'd0, 16'd100);
        read1("pp_b1_addr6", 4'd6, 16'd101);

        // Misplaced s_last and missing final s_last.
        do_reset();
        s0 = starts;
        stream(0, 6, 5);
        @(negedge clk);
        chk("ferr_early_last", 32'(frame_err), 1);
        stream(6, 6, -1);
        repeat (3) tick();
        chk("ferr_sticky", 32'(frame_err), 1);
        chk("ferr_lat3", 32'(frame_err3), 1);
        chk("ferr_bank_full", 32'(bank_full), 1);
        chk("ferr_starts", starts - s0, 1);

        // Reset mid-frame discards the partial frame and ignores a stray done.
        do_reset();
        s0 = starts;
        stream(0, 5, -1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_ready", 32'(s_ready), 1);
        chk("mid_rst_bank_full", 32'(bank_full), 0);
        chk("mid_rst_frame_err", 32'(frame_err), 0);
        pulse_done();
        repeat (3) tick();
        chk("mid_rst_no_start", starts - s0, 0);
        chk("mid_rst_done_ignored", 32'(bank_full), 0);
        stream(0, 12, 11);
        repeat (3) tick();
        chk("mid_rst_starts", starts - s0, 1);
        read1("mid_rst_addr6", 4'd6, 16'd1);

        // LAT=3 copy: exact arrival, hold, out-of-range zero.
        repeat (4) tick();
        chk("lat3_prev", 32'(in_q3), 1);
        in_addr = 4'd7;
        in_en   = 1'b1;
        tick();
        in_en = 1'b0;
        @(negedge clk);
        chk("lat3_cyc1", 32'(in_q3), 1);
        @(negedge clk);
        chk("lat3_cyc2", 32'(in_q3), 1);
        @(negedge clk);
        chk("lat3_cyc3", 32'(in_q3), 3);
        repeat (3) @(negedge clk);
        chk("lat3_hold", 32'(in_q3), 3);
        in_addr = 4'd12;
        in_en   = 1'b1;
        tick();
        in_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat3_oor", 32'(in_q3), 0);
        chk("lat1_oor", 32'(in_q), 0);
        in_addr = 4'd6;
        repeat (4) @(negedge clk);
        chk("noen_hold_lat1", 32'(in_q), 0);
        chk("noen_hold_lat3", 32'(in_q3), 0);
        chk("lat3_bank_full", 32'(bank_full3), 1);
        chk("lat3_s_ready", 32'(s_ready3), 1);

        chk("total_starts", starts, 8);
        chk("total_starts_lat3", starts3, 8);
        chk("start_width", wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fc_in_buffer.md
Name: fc_in_buffer

Overview:
- Ping-pong flatten buffer between the final pooling stage and the first dense layer.
- Accepts pooled features as a valid/ready stream in pixel-interleaved order (all channels of one pixel, then the next pixel), writes each beat to its channel-major flattened address, and serves the dense layer's synchronous read port.
- Issues dense_start once a bank holds a complete frame and releases that bank on dense_done.

Parameters:
- DATA_WIDTH, 16, feature word width (signed)
- CHANNELS, 8, feature-map channels
- H, 14, feature-map rows
- W, 14, feature-map columns
- LAT, 1, read latency from in_en to valid in_q; legal range 1..4; must equal the consuming dense LAT
- IN_DIM, CHANNELS*H*W, derived; flattened vector length

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  buffer can accept a beat
- s_data  in  DATA_WIDTH  signed feature value
- s_last  in  1  advisory end-of-frame marker
- dense_start  out  1  one-cycle start pulse to dense
- dense_done  in  1  dense completion pulse
- in_addr  in  clog2(IN_DIM)  dense read address
- in_en  in  1  dense read request
- in_q  out  DATA_WIDTH  read data, valid LAT cycles after in_en
- frame_err  out  1  sticky framing error
- bank_full  out  2  per-bank full flags (status)

Behaviour:
- Reset values: s_ready=1, dense_start=0, in_q=0, frame_err=0, bank_full=00. Write bank and read bank select = 0. Write counters = 0. Read FSM = R_IDLE. RAM contents are not cleared.
- Write order and counters: ch is the fastest counter, then col, then row.
- Write address: ch*H*W + row*W + col. Generated incrementally, with no multipliers:
  - pix_base = row*W + col
  - ch_off steps by H*W
- s_ready = ~bank_full[wr_sel]. Combinational from registers only; no dependence on s_valid.
- Accept: s_valid && s_ready. Data is written to bank wr_sel at the computed address.
- Final beat (ch=CHANNELS-1, col=W-1, row=H-1) accepted at edge k:
  - bank_full[wr_sel] sets at edge k
  - wr_sel toggles
  - counters clear
- s_last is advisory only:
  - s_last accepted with a beat that is not the final beat sets frame_err.
  - A final beat accepted without s_last also sets frame_err.
  - frame_err stays set until reset.
  - Counters are position-driven and unaffected by s_last.
- Read FSM:
  - R_IDLE: if bank_full[rd_sel], register dense_start=1 and go to R_BUSY. dense_start therefore goes high one cycle after the full flag first reads 1, and lasts exactly one cycle.
  - R_BUSY: on dense_done, clear bank_full[rd_sel], toggle rd_sel, go to R_IDLE.
  - dense_done seen in R_IDLE is ignored.
- Read path:
  - in_en registers a read of bank rd_sel, plus LAT-1 additional pipeline stages.
  - in_q updates exactly LAT cycles after in_en and holds until the next completed read.
  - in_addr >= IN_DIM returns 0.
  - Reads without in_en do not change in_q.
- Simultaneous events:
  - Write-completion on one bank and release on the other bank in the same cycle: both flag updates apply.
  - Release of the bank that the writer is stalled on: s_ready rises the next cycle.
  - There is at least one idle cycle between dense_done and the next dense_start.
- Reset mid-operation: any partial frame is discarded and all flags clear. dense_done arriving after reset is ignored, because the FSM is in R_IDLE.
- Throughput: 1 beat/cycle on the write side while a bank is free. Reads and writes to opposite banks are concurrent.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_WIDTH
  - FRAC_BITS
  - CHANNELS/H/W constants for the last pool stage
  - IN_DIM
  - the feature word typedef
- Sub-module fc_buf_ram: simple dual-port RAM, 2*IN_DIM deep, with the bank bit as the address MSB.
  - One write port.
  - One read port with the LAT output pipeline and out-of-range zeroing.
  - Inferred as block RAM.

Test Plan (CHANNELS=2, H=2, W=3, IN_DIM=12; beat n carries value n):
- Stream 12 beats 0..11 with s_last on beat 11 -> one dense_start pulse, bank_full=01. Reads:
  - addr 6 -> in_q=1
  - addr 7 -> 3
  - addr 5 -> 10
  - addr 11 -> 11
  - each arriving LAT=1 cycle after in_en
- Stream 36 beats with no dense_done -> s_ready drops after beat 23 is accepted, bank_full=11. A dense_done pulse raises s_ready the next cycle, and beats 24..35 then land in bank 0.
- Two frames (0..11, then 100..111) -> after the first dense_done, a second dense_start follows. Reads then come from bank 1:
  - addr 0 -> 100
  - addr 6 -> 101
- s_last on beat 5 and none on beat 11 -> frame_err=1 stays set. The frame still completes and dense_start is issued.
- Reset after 5 beats -> s_ready=1, bank_full=00, no dense_start. A fresh 12-beat frame then reads addr 6 -> 1.
- LAT=3 build -> in_q changes exactly 3 cycles after in_en and holds while in_en is low. addr 12 -> in_q=0.
